reg_wb_queue: RTL

//  Write side of the 17-entry register bank (R0-R15, R16=RET). Buffers writeback requests from the
//  ALU and memory (load) paths in a small FIFO and drains one per cycle onto the bank's single write

---
 rtl/reg_wb_queue_pkg.sv | 20 ++
 rtl/reg_wb_queue_if.sv | 33 +++
 rtl/reg_wb_queue_wb_fifo.sv | 54 +++++
 rtl/reg_wb_queue.sv | 92 +++++++++
 4 files changed

// File: rtl/reg_wb_queue_pkg.sv
// Shared types and constants for the register-bank writeback queue.
// Register indices, data width and the queued writeback entry layout.
package reg_wb_queue_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 17;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RET  = 5'd16;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // R0 is hardwired and anything at or beyond nregs does not exist.
  function automatic logic dest_writable(logic [REG_W-1:0] d, int nregs);
    return (d != REG_ZERO) && (32'(d) < nregs);
  endfunction
endpackage

// File: rtl/reg_wb_queue_if.sv
// Writeback request, bank write port and decode scoreboard signals of reg_wb_queue.
// master = producer/decode side, slave = the queue itself.
interface reg_wb_queue_if;
  import reg_wb_queue_pkg::*;

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_W-1:0]  mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_W-1:0]  alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              wrReg;
  logic [REG_W-1:0]  destReg;
  logic [DATA_W-1:0] wrData;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic              busy_rs;
  logic              busy_rt;
  logic              empty;
  logic              err;

  modport master (
    output mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data, rs, rt,
    input  mem_ready, alu_ready, wrReg, destReg, wrData, busy_rs, busy_rt, empty, err
  );

  modport slave (
    input  mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data, rs, rt,
    output mem_ready, alu_ready, wrReg, destReg, wrData, busy_rs, busy_rt, empty, err
  );
endinterface

// File: rtl/reg_wb_queue_wb_fifo.sv
// Circular buffer taking up to two pushes and one pop per cycle.
// When both pushes fire, push0 lands first (older) and push1 right behind it.
module wb_fifo
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  wb_entry_t     push0_entry,
  input  logic          push1,
  input  wb_entry_t     push1_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          empty
);
  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] tail_plus1;
  logic [CW-1:0] push_n;
  logic          pop_eff;

  assign tail_plus1 = tail_reg + PW'(1);
  assign push_n     = CW'(push0) + CW'(push1);
  assign pop_eff    = pop & (count_reg != '0);

  // Storage carries no reset; only valid slots are ever read.
  always_ff @(posedge clk) begin
    if (push0) mem[tail_reg] <= push0_entry;
    if (push1) mem[push0 ? tail_plus1 : tail_reg] <= push1_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PW'(pop_eff);
      tail_reg  <= tail_reg + PW'(push_n);
      count_reg <= count_reg + push_n - CW'(pop_eff);
    end
  end

  assign head  = mem[head_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);
endmodule

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the register bank: merges mem/ALU writebacks, drains one
// per cycle, and tracks per-register pending writes so decode can stall on rs/rt.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int NREGS = 17
) (
  input logic          clk,
  input logic          rst,
  reg_wb_queue_if.slave wb
);
  import reg_wb_queue_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          empty;
  wb_entry_t     head;
  wb_entry_t     mem_entry;
  wb_entry_t     alu_entry;
  logic          mem_acc, alu_acc;
  logic          mem_keep, alu_keep;
  logic          bad_dest;
  logic          pop;
  logic          err_reg;
  logic [2**REG_W-1:0] pend_nz;

  // Ready uses registered occupancy only, so a same-cycle pop never frees a slot.
  assign free         = CW'(DEPTH) - count;
  assign wb.mem_ready = (free != '0);
  assign wb.alu_ready = (free >= CW'(2)) | ((free != '0) & ~wb.mem_valid);

  assign mem_acc  = wb.mem_valid & wb.mem_ready;
  assign alu_acc  = wb.alu_valid & wb.alu_ready;
  assign mem_keep = mem_acc & dest_writable(wb.mem_dest, NREGS);
  assign alu_keep = alu_acc & dest_writable(wb.alu_dest, NREGS);
  assign bad_dest = (mem_acc & (32'(wb.mem_dest) >= NREGS)) |
                    (alu_acc & (32'(wb.alu_dest) >= NREGS));

  assign mem_entry = '{dest: wb.mem_dest, data: wb.mem_data};
  assign alu_entry = '{dest: wb.alu_dest, data: wb.alu_data};
  assign pop       = ~empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (mem_keep),
    .push0_entry (mem_entry),
    .push1       (alu_keep),
    .push1_entry (alu_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .empty       (empty)
  );

  assign wb.wrReg   = ~empty;
  assign wb.destReg = empty ? '0 : head.dest;
  assign wb.wrData  = empty ? '0 : head.data;
  assign wb.empty   = empty;

  always_ff @(posedge clk) begin
    if (rst) err_reg <= 1'b0;
    else if (bad_dest) err_reg <= 1'b1;
  end
  assign wb.err = err_reg;

  // One pending counter per architectural register; enqueue and pop of the same reg cancel.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    logic [CW-1:0] pending_reg;
    logic          inc_mem, inc_alu, dec;

    assign inc_mem = mem_keep & (wb.mem_dest == REG_W'(gi));
    assign inc_alu = alu_keep & (wb.alu_dest == REG_W'(gi));
    assign dec     = pop & (head.dest == REG_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) pending_reg <= '0;
      else pending_reg <= pending_reg + CW'(inc_mem) + CW'(inc_alu) - CW'(dec);
    end

    assign pend_nz[gi] = (pending_reg != '0);
  end

  // Indices that name no register read as never busy.
  for (genvar gi = NREGS; gi < 2**REG_W; gi++) begin : g_pend_pad
    assign pend_nz[gi] = 1'b0;
  end

  assign wb.busy_rs = (wb.rs != REG_ZERO) & pend_nz[wb.rs];
  assign wb.busy_rt = (wb.rt != REG_ZERO) & pend_nz[wb.rt];
endmodule
